// File: rtl/aes_fault_bist.sv
// Built-in self-test sequencer for the fault-defended AES top: it replays stored vectors
// clean and with a one-cycle state fault, and keeps saturating pass/fail tallies.
module aes_fault_bist #(
  parameter int           NUM_VECTORS     = 16,
  parameter int           ADDR_W          = 8,
  parameter int           CNT_W           = 16,
  parameter int           TIMEOUT_CYCLES  = 4000,
  parameter int           INJECT_DELAY    = 4,
  parameter logic [127:0] FAULT_MASK_INIT = 128'h1,
  parameter bit           ROTATE_FAULT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [127:0]      vec_key,
  input  logic [127:0]      vec_pt,
  input  logic [127:0]      vec_ct,
  output logic              dut_start,
  output logic [127:0]      dut_key,
  output logic [127:0]      dut_pt,
  output logic              fault_inj,
  output logic [127:0]      fault_mask,
  input  logic              dut_busy,
  input  logic              dut_done,
  input  logic              dut_fault_flag,
  input  logic [127:0]      dut_ct,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              timeout,
  output logic [CNT_W-1:0]  pass_ok,
  output logic [CNT_W-1:0]  fail_ok,
  output logic [CNT_W-1:0]  pass_fault,
  output logic [CNT_W-1:0]  fail_fault,
  output logic              result_pass
);

  localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CYC_W-1:0]  INJ_AT   = CYC_W'(INJECT_DELAY - 1);
  // cyc reads k-1 in the k-th cycle after dut_start, so this is the last RUN cycle in budget.
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(TIMEOUT_CYCLES - 2);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_VECTORS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_RUN, S_CHECK, S_GAP, S_NEXT, S_DONE, S_TIMEOUT
  } state_t;

  state_t             state, state_d;
  logic [1:0]         mode_q;
  logic [ADDR_W-1:0]  idx;
  logic               fault_phase;
  logic [CYC_W-1:0]   cyc;
  logic [127:0]       exp_ct;
  logic               flag_q;
  logic               ct_ok_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign vec_addr = idx;

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    dut_start = 1'b0;
    fault_inj = 1'b0;
    bist_busy = 1'b1;
    unique case (state)
      S_IDLE: begin
        bist_busy = 1'b0;
        if (go) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: begin
        dut_start = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (dut_done) begin
          state_d = S_CHECK;
        end else begin
          // A core that has already gone idle has no state register worth corrupting.
          fault_inj = fault_phase && dut_busy && (cyc == INJ_AT);
          if (cyc == CYC_LAST) state_d = S_TIMEOUT;
        end
      end
      S_CHECK: state_d = S_GAP;
      S_GAP:   state_d = (mode_q[1] && !fault_phase) ? S_START : S_NEXT;
      S_NEXT:  state_d = (idx == IDX_LAST) ? S_DONE : S_FETCH;
      S_DONE, S_TIMEOUT: begin
        bist_busy = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments, so every register here samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mode_q      <= '0;
      idx         <= '0;
      fault_phase <= 1'b0;
      cyc         <= '0;
      // NOTE: the wide data registers are reset as well, so dut_key/dut_pt read 0 out of reset.
      dut_key     <= '0;
      dut_pt      <= '0;
      exp_ct      <= '0;
      flag_q      <= 1'b0;
      ct_ok_q     <= 1'b0;
      pass_ok     <= '0;
      fail_ok     <= '0;
      pass_fault  <= '0;
      fail_fault  <= '0;
      bist_done   <= 1'b0;
      timeout     <= 1'b0;
      result_pass <= 1'b0;
      fault_mask  <= FAULT_MASK_INIT;
    end else begin
      state <= state_d;
      unique case (state)
        S_IDLE: if (go) begin
          mode_q      <= mode;
          idx         <= '0;
          pass_ok     <= '0;
          fail_ok     <= '0;
          pass_fault  <= '0;
          fail_fault  <= '0;
          bist_done   <= 1'b0;
          timeout     <= 1'b0;
          result_pass <= 1'b0;
          fault_mask  <= FAULT_MASK_INIT;
        end
        S_LOAD: begin
          dut_key     <= vec_key;
          dut_pt      <= vec_pt;
          exp_ct      <= vec_ct;
          fault_phase <= (mode_q == 2'd1);
        end
        S_START: cyc <= '0;
        S_RUN: begin
          cyc <= cyc + 1'b1;
          if (dut_done) begin
            flag_q  <= dut_fault_flag;
            ct_ok_q <= (dut_ct == exp_ct);
          end else if (cyc == CYC_LAST) begin
            timeout     <= 1'b1;
            bist_done   <= 1'b1;
            result_pass <= 1'b0;
          end
        end
        S_CHECK: begin
          if (fault_phase) begin
            if (flag_q) pass_fault <= sat_inc(pass_fault);
            else        fail_fault <= sat_inc(fail_fault);
            if (ROTATE_FAULT) fault_mask <= {fault_mask[126:0], fault_mask[127]};
          end else begin
            if (!flag_q && ct_ok_q) pass_ok <= sat_inc(pass_ok);
            else                    fail_ok <= sat_inc(fail_ok);
          end
        end
        S_GAP: if (mode_q[1] && !fault_phase) fault_phase <= 1'b1;
        S_NEXT: begin
          if (idx != IDX_LAST) begin
            idx <= idx + 1'b1;
          end else begin
            bist_done   <= 1'b1;
            result_pass <= (fail_ok == '0) && (fail_fault == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_fault_bist.sv
// Directed bench for aes_fault_bist: a vector ROM, an oracle AES top with latency/fault knobs,
// a run-sequence monitor, and an end-of-run model of the counters, mask and verdict.
module tb_aes_fault_bist;

  localparam int NV = 5;
  localparam int AW = 8;
  localparam int CW = 2;
  localparam int TO = 20;
  localparam int ID = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] vec_addr;
  logic [127:0]  vec_key, vec_pt, vec_ct;
  logic          dut_start, fault_inj;
  logic [127:0]  dut_key, dut_pt, fault_mask;
  logic          dut_busy, dut_done, dut_fault_flag;
  logic [127:0]  dut_ct;
  logic          bist_busy, bist_done, timeout, result_pass;
  logic [CW-1:0] pass_ok, fail_ok, pass_fault, fail_fault;

  aes_fault_bist #(
    .NUM_VECTORS(NV), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT_CYCLES(TO), .INJECT_DELAY(ID),
    .FAULT_MASK_INIT(128'h1), .ROTATE_FAULT(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .vec_addr(vec_addr),
    .vec_key(vec_key), .vec_pt(vec_pt), .vec_ct(vec_ct),
    .dut_start(dut_start), .dut_key(dut_key), .dut_pt(dut_pt),
    .fault_inj(fault_inj), .fault_mask(fault_mask),
    .dut_busy(dut_busy), .dut_done(dut_done), .dut_fault_flag(dut_fault_flag), .dut_ct(dut_ct),
    .bist_busy(bist_busy), .bist_done(bist_done), .timeout(timeout),
    .pass_ok(pass_ok), .fail_ok(fail_ok), .pass_fault(pass_fault), .fail_fault(fail_fault),
    .result_pass(result_pass)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scenario knobs for the oracle AES top and the vector ROM.
  int            lat_k = 10;
  bit            ignore_k = 1'b0;
  logic [NV-1:0] corrupt_k = '0;

  logic [127:0] mem_key [NV];
  logic [127:0] mem_pt  [NV];
  logic [127:0] gold_ct [NV];

  always @(posedge clk) begin
    if (int'(vec_addr) < NV) begin
      vec_key <= mem_key[vec_addr];
      vec_pt  <= mem_pt[vec_addr];
      vec_ct  <= gold_ct[vec_addr] ^ (corrupt_k[vec_addr] ? 128'h00ff : 128'h0);
    end
  end

  function automatic logic [127:0] oracle_ct(input logic [127:0] k, input logic [127:0] p);
    for (int i = 0; i < NV; i++)
      if (mem_key[i] == k && mem_pt[i] == p) return gold_ct[i];
    return '0;
  endfunction

  // Oracle AES top: dut_done rises lat_k cycles after dut_start; an honoured injection
  // raises the fault flag and garbles the ciphertext.
  int           m_cnt;
  bit           m_faulted;
  logic [127:0] m_key, m_pt;
  always @(posedge clk) begin
    if (!rst_n) begin
      dut_busy <= 1'b0; dut_done <= 1'b0; dut_fault_flag <= 1'b0; dut_ct <= '0;
      m_cnt <= 0; m_faulted <= 1'b0;
    end else begin
      dut_done <= 1'b0;
      if (dut_start) begin
        dut_busy <= 1'b1; m_cnt <= 1; m_faulted <= 1'b0; m_key <= dut_key; m_pt <= dut_pt;
      end else if (dut_busy) begin
        m_cnt <= m_cnt + 1;
        if (fault_inj && !ignore_k) m_faulted <= 1'b1;
        if (m_cnt == lat_k - 1) begin
          dut_busy       <= 1'b0;
          dut_done       <= 1'b1;
          dut_fault_flag <= m_faulted || (fault_inj && !ignore_k);
          dut_ct         <= (m_faulted || (fault_inj && !ignore_k)) ? ~oracle_ct(m_key, m_pt)
                                                                   : oracle_ct(m_key, m_pt);
        end
      end
    end
  end

  // Compare process: expected run order (vector, phase), key/pt per run, injection timing and mask.
  int runq[$];
  bit in_run = 1'b0;
  bit cur_fault = 1'b0;
  int since = 0;
  int vi = 0;
  int fault_n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      runq.delete();
      in_run = 1'b0;
    end else begin
      if (go && !bist_busy) begin
        runq.delete();
        for (int i = 0; i < NV; i++) begin
          if (mode != 2'd1) runq.push_back(2 * i);
          if (mode != 2'd0) runq.push_back(2 * i + 1);
        end
        fault_n = 0;
        in_run  = 1'b0;
      end
      if (dut_start) begin
        check("start_expected", 128'(runq.size() != 0), 128'd1);
        if (runq.size() != 0) begin
          vi        = runq[0] / 2;
          cur_fault = (runq[0] % 2) == 1;
          void'(runq.pop_front());
        end
        in_run = 1'b1;
        since  = 0;
      end else if (in_run) begin
        since++;
      end
      if (in_run) begin
        check("dut_key", dut_key, mem_key[vi]);
        check("dut_pt", dut_pt, mem_pt[vi]);
      end
      check("fault_inj", 128'(fault_inj),
            128'(in_run && cur_fault && lat_k > ID && since == ID));
      if (fault_inj) check("inj_mask", fault_mask, 128'h1 << fault_n);
      if (in_run && dut_done) begin
        in_run = 1'b0;
        if (cur_fault) fault_n++;
      end
      if (bist_done) in_run = 1'b0;
    end
  end

  typedef struct packed {
    int           p_ok, f_ok, p_fault, f_fault;
    bit           result, tmo;
    logic [127:0] mask;
  } exp_t;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // End-of-run prediction straight from the scenario: no CHECK happens if the first run times out.
  function automatic exp_t predict(input logic [1:0] m, input int lat, input bit ign,
                                   input logic [NV-1:0] cor);
    exp_t e;
    int   good, bad;
    bit   clean_on, fault_on, hit;
    e = '0;
    e.mask = 128'h1;
    if (lat >= TO) begin
      e.tmo = 1'b1;
      return e;
    end
    clean_on = (m != 2'd1);
    fault_on = (m != 2'd0);
    hit      = !ign && (lat > ID);
    good     = 0;
    for (int i = 0; i < NV; i++) if (!cor[i]) good++;
    bad       = NV - good;
    e.p_ok    = clean_on ? sat(good) : 0;
    e.f_ok    = clean_on ? sat(bad) : 0;
    e.p_fault = (fault_on && hit) ? sat(NV) : 0;
    e.f_fault = (fault_on && !hit) ? sat(NV) : 0;
    e.result  = (e.f_ok == 0) && (e.f_fault == 0);
    if (fault_on) e.mask = 128'h1 << NV;
    return e;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, ".dut_start"}, 128'(dut_start), 128'd0);
    check({tag, ".fault_inj"}, 128'(fault_inj), 128'd0);
    check({tag, ".bist_busy"}, 128'(bist_busy), 128'd0);
    check({tag, ".bist_done"}, 128'(bist_done), 128'd0);
    check({tag, ".timeout"}, 128'(timeout), 128'd0);
    check({tag, ".result"}, 128'(result_pass), 128'd0);
    check({tag, ".counts"}, 128'({pass_ok, fail_ok, pass_fault, fail_fault}), 128'd0);
    check({tag, ".vec_addr"}, 128'(vec_addr), 128'd0);
    check({tag, ".dut_key"}, dut_key, 128'd0);
    check({tag, ".mask"}, fault_mask, 128'h1);
  endtask

  task automatic run_bist(input string tag, input logic [1:0] m, input int lat, input bit ign,
                          input logic [NV-1:0] cor, input bit mid_go);
    exp_t e;
    int   k, since_s;
    bit   seen;
    e = predict(m, lat, ign, cor);
    lat_k = lat; ignore_k = ign; corrupt_k = cor;
    @(posedge clk); #1; mode = m; go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check({tag, ".busy_after_go"}, 128'(bist_busy), 128'd1);
        check({tag, ".done_cleared"}, 128'(bist_done), 128'd0);
      end
      if (dut_start) seen = 1'b1;
    end
    check({tag, ".go_to_start"}, 128'(k), 128'd3);
    since_s = 0; k = 0;
    while (!bist_done && k < 3000) begin
      @(negedge clk);
      k++;
      if (mid_go && k == 30) begin go = 1'b1; mode = 2'd1; end
      if (mid_go && k == 31) go = 1'b0;
      if (dut_start) since_s = 0; else since_s++;
    end
    check({tag, ".done_reached"}, 128'(bist_done), 128'd1);
    check({tag, ".busy_at_done"}, 128'(bist_busy), 128'd0);
    if (e.tmo) check({tag, ".timeout_latency"}, 128'(since_s), 128'(TO));
    else       check({tag, ".runs_left"}, 128'(runq.size()), 128'd0);
    repeat (3) @(negedge clk);
    check({tag, ".done_held"}, 128'(bist_done), 128'd1);
    check({tag, ".timeout"}, 128'(timeout), 128'(e.tmo));
    check({tag, ".result"}, 128'(result_pass), 128'(e.result));
    check({tag, ".pass_ok"}, 128'(pass_ok), 128'(e.p_ok));
    check({tag, ".fail_ok"}, 128'(fail_ok), 128'(e.f_ok));
    check({tag, ".pass_fault"}, 128'(pass_fault), 128'(e.p_fault));
    check({tag, ".fail_fault"}, 128'(fail_fault), 128'(e.f_fault));
    check({tag, ".mask"}, fault_mask, e.mask);
  endtask

  initial begin
    int k, starts;
    mem_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
    mem_pt[0]  = 128'h00112233445566778899aabbccddeeff;
    gold_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int i = 1; i < NV; i++) begin
      mem_key[i] = {4{32'(32'h01020300 + i)}};
      mem_pt[i]  = {4{32'(32'habcd0000 ^ i)}};
      gold_ct[i] = {4{32'(32'hc0de0000 + 7 * i)}};
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset("reset");

    run_bist("A", 2'd0, 10, 1'b0, 5'b00000, 1'b0);
    check("A.lit_pass_ok", 128'(pass_ok), 128'd3);
    check("A.lit_result", 128'(result_pass), 128'd1);

    run_bist("B", 2'd2, 10, 1'b0, 5'b00000, 1'b1);
    check("B.lit_pass_fault", 128'(pass_fault), 128'd3);
    check("B.lit_mask", fault_mask, 128'h20);

    run_bist("C", 2'd1, 10, 1'b1, 5'b00000, 1'b0);
    check("C.lit_fail_fault", 128'(fail_fault), 128'd3);
    check("C.lit_result", 128'(result_pass), 128'd0);

    run_bist("D", 2'd0, 10, 1'b0, 5'b00010, 1'b0);
    check("D.lit_fail_ok", 128'(fail_ok), 128'd1);

    run_bist("E", 2'd0, 10, 1'b0, 5'b11111, 1'b0);
    check("E.lit_fail_ok_sat", 128'(fail_ok), 128'd3);

    run_bist("F", 2'd1, ID, 1'b0, 5'b00000, 1'b0);
    check("F.lit_fail_fault", 128'(fail_fault), 128'd3);

    run_bist("G", 2'd2, TO - 1, 1'b0, 5'b00000, 1'b0);
    check("G.lit_result", 128'(result_pass), 128'd1);

    run_bist("H", 2'd0, 1000, 1'b0, 5'b00000, 1'b0);
    check("H.lit_timeout", 128'(timeout), 128'd1);
    check("H.lit_pass_ok", 128'(pass_ok), 128'd0);

    run_bist("A2", 2'd0, 10, 1'b0, 5'b00000, 1'b0);
    check("A2.lit_timeout", 128'(timeout), 128'd0);

    lat_k = 10; ignore_k = 1'b0; corrupt_k = '0;
    @(posedge clk); #1; mode = 2'd2; go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    k = 0; starts = 0;
    while (starts < 2 && k < 200) begin
      @(negedge clk);
      k++;
      if (dut_start) starts++;
    end
    check("R.two_starts", 128'(starts), 128'd2);
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check_reset("R");

    run_bist("R3", 2'd3, 10, 1'b0, 5'b00000, 1'b0);
    check("R3.lit_pass_ok", 128'(pass_ok), 128'd3);
    check("R3.lit_mask", fault_mask, 128'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
